dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Data-memory access sequencer between the memory stage and the L1 data cache.
//  - Takes one load/store request per instruction, drives the 128-bit line interface, waits for dmem_resp and stalls the pipeline meanwhile.
//  - Returns the extracted 16-bit word/byte for writeback.
//  - Generates line byte enables and replicated write data, so the memory stage only supplies address, data and size.
// PARAMETERS
//  LINE_BYTES     16   cache line width in bytes; LINE_W = 8*LINE_BYTES (=128)
//  TIMEOUT_CYCLES 255  max cycles in ACCESS/IND_PTR without dmem_resp; 0 = no timeout
// PORTS
//  clk              in   1    clock, all state on rising edge
//  reset            in   1    asynchronous, active-high reset
//  req_valid        in   1    memory stage holds a load/store this cycle
//  req_write        in   1    1 = store, 0 = load
//  req_byte         in   1    1 = byte access (LDB/STB), 0 = word
//  req_indirect     in   1    LDI/STI: address is a pointer (DMEM_INDIRECT_EN only)
//  req_addr         in   16   byte address
//  req_wdata        in   16   store data (byte stores use [7:0])
//  dmem_address     out  16   address to cache (registered)
//  dmem_read        out  1    cache read strobe, held until dmem_resp
//  dmem_write       out  1    cache write strobe, held until dmem_resp
//  dmem_wdata       out  128  replicated store data
//  dmem_byte_enable out  16   per-byte write enable
//  dmem_resp        in   1    cache completes current access
//  dmem_rdata       in   128  cache read line, valid with dmem_resp
//  stall            out  1    freeze pipeline upstream of writeback
//  done             out  1    one-cycle pulse: access finished, rdata_out/err valid
//  rdata_out        out  16   load result, held until next done
//  err              out  1    misalign/timeout flag, valid with done
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-access abandons the access; a later dmem_resp seen in IDLE is ignored.
//  - States:
//    - IDLE: stall = req_valid (combinational). On req_valid, latch request.
//      - Word access with addr[0]=1 -> DONE, err=1, no cache access.
//      - Otherwise -> ACCESS (or IND_PTR when indirect).
//    - ACCESS: dmem_read or dmem_write = 1, stall = 1.
//      - On dmem_resp -> DONE; load data captured the same edge.
//    - DONE: done = 1, stall = 0, strobes 0 -> IDLE. req_valid this cycle is ignored; it is the same instruction advancing.
//  - Latency: request accepted at cycle 0 (IDLE edge); strobe asserted from cycle 1; resp at cycle n -> done at cycle n+1. Minimum 2 cycles.
//  - Load extract: word = dmem_rdata[16*addr[3:1] +: 16]; byte = that word's [8*addr[0] +: 8], zero-extended to 16 bits.
//  - Store, word: byte_enable = 16'b11 << (2*addr[3:1]); wdata = {8{req_wdata}}.
//  - Store, byte: byte_enable = 16'b1 << addr[3:0]; wdata = {16{req_wdata[7:0]}}.
//  - byte_enable = 0 on loads and in IDLE/DONE.
//  - dmem_address = latched req_addr with [3:0] unchanged; the cache ignores the offset.
//  - Timeout: counter clears on entry to ACCESS/IND_PTR and increments each cycle without resp.
//    - On reaching TIMEOUT_CYCLES: drop strobe -> DONE, err=1, rdata_out=0.
//    - dmem_resp in the same cycle as the timeout wins (normal completion).
//  - err = 0 on normal completion. rdata_out is unchanged on stores.
// CONFIGURATION
//  - DMEM_INDIRECT_EN defined:
//    - req_indirect=1 enters IND_PTR: dmem_read at req_addr, word-aligned; addr[0]=1 -> err.
//    - On resp, pointer = extracted word; dmem_address <= pointer; -> ACCESS for the final load/store.
//    - Misaligned word pointer -> DONE, err=1.
//    - Timeout applies separately to each phase.
//  - Not defined: IND_PTR state absent; req_indirect ignored.
// TESTING
//  - Word load addr=0x1236, resp after 3 cycles, rdata word3=0xBEEF -> done at cycle 4, rdata_out=0xBEEF, err=0, stall high cycles 0-3.
//  - Byte store addr=0x2005, wdata=0x12AB -> byte_enable=0x0020, wdata=16{0xAB}, dmem_write until resp.
//  - Byte load addr=0x2007, line byte7=0x9C -> rdata_out=0x009C. Word load addr=0x2003 -> done next cycle, err=1, no dmem_read.
//  - TIMEOUT_CYCLES=4, resp never arrives -> strobe drops after 4 cycles, done with err=1. Resp on the 4th cycle -> err=0.
//  - Reset asserted mid-ACCESS -> outputs 0 immediately. Stray resp next cycle -> no done. New request then completes normally.
//  - DMEM_INDIRECT_EN: LDI addr=0x0010, mem[0x0010]=0x0040, mem[0x0040]=0x5A5A -> two read phases, rdata_out=0x5A5A. STI writes to 0x0040.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the memory stage and a line-wide L1 data cache.
// Optional pointer-indirect accesses (LDI/STI) are enabled with `define DMEM_INDIRECT_EN.
module dmem_access_ctrl #(
  parameter int LINE_BYTES     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic                    req_indirect,
  input  logic [15:0]             req_addr,
  input  logic [15:0]             req_wdata,
  output logic [15:0]             dmem_address,
  output logic                    dmem_read,
  output logic                    dmem_write,
  output logic [8*LINE_BYTES-1:0] dmem_wdata,
  output logic [LINE_BYTES-1:0]   dmem_byte_enable,
  input  logic                    dmem_resp,
  input  logic [8*LINE_BYTES-1:0] dmem_rdata,
  output logic                    stall,
  output logic                    done,
  output logic [15:0]             rdata_out,
  output logic                    err
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef DMEM_INDIRECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, IND_PTR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t              state, state_nxt;
  logic                wr_q, byte_q;
  logic [15:0]         wdata_q;
  logic [TCNT_W-1:0]   tcnt;
  logic                tmo_hit, req_misalign;
  logic [15:0]         ptr_word;
  logic                ptr_misalign;

  function automatic logic [15:0] extract(input logic [LINE_W-1:0] line,
                                          input logic [15:0] a, input logic b);
    logic [15:0] w;
    w = line[16*a[OFF_W-1:1] +: 16];
    if (b) return {8'h00, (a[0] ? w[15:8] : w[7:0])};
    return w;
  endfunction

  function automatic logic [LINE_BYTES-1:0] line_be(input logic [15:0] a, input logic b);
    if (b) return {{(LINE_BYTES-1){1'b0}}, 1'b1} << a[OFF_W-1:0];
    return {{(LINE_BYTES-2){1'b0}}, 2'b11} << {a[OFF_W-1:1], 1'b0};
  endfunction

  function automatic logic [LINE_W-1:0] line_wdata(input logic [15:0] d, input logic b);
    if (b) return {LINE_BYTES{d[7:0]}};
    return {(LINE_BYTES/2){d}};
  endfunction

  // A response arriving in the expiry cycle still completes normally.
  assign tmo_hit      = (TIMEOUT_CYCLES != 0) && (tcnt == TCNT_LAST) && !dmem_resp;
  assign ptr_word     = extract(dmem_rdata, dmem_address, 1'b0);
  assign ptr_misalign = !byte_q && ptr_word[0];
`ifdef DMEM_INDIRECT_EN
  assign req_misalign = req_addr[0] && (!req_byte || req_indirect);
`else
  assign req_misalign = req_addr[0] && !req_byte;
  logic unused_indirect;
  assign unused_indirect = req_indirect;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_misalign)      state_nxt = DONE;
`ifdef DMEM_INDIRECT_EN
          else if (req_indirect) state_nxt = IND_PTR;
`endif
          else                   state_nxt = ACCESS;
        end
      end
      ACCESS: if (dmem_resp || tmo_hit) state_nxt = DONE;
`ifdef DMEM_INDIRECT_EN
      IND_PTR: begin
        if (dmem_resp)    state_nxt = ptr_misalign ? DONE : ACCESS;
        else if (tmo_hit) state_nxt = DONE;
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall            = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    done             = 1'b0;
    dmem_byte_enable = '0;
    dmem_wdata       = '0;
    case (state)
      IDLE: stall = req_valid;
      ACCESS: begin
        stall      = 1'b1;
        dmem_read  = !wr_q;
        dmem_write = wr_q;
        if (wr_q) begin
          dmem_byte_enable = line_be(dmem_address, byte_q);
          dmem_wdata       = line_wdata(wdata_q, byte_q);
        end
      end
`ifdef DMEM_INDIRECT_EN
      IND_PTR: begin
        stall     = 1'b1;
        dmem_read = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Request payload; only observed while a strobe is up, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      byte_q  <= req_byte;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_address <= '0;
      rdata_out    <= '0;
      err          <= 1'b0;
      tcnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dmem_address <= req_addr;
            err          <= req_misalign;
            tcnt         <= '0;
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            err <= 1'b0;
            if (!wr_q) rdata_out <= extract(dmem_rdata, dmem_address, byte_q);
          end else if (tmo_hit) begin
            err       <= 1'b1;
            rdata_out <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`ifdef DMEM_INDIRECT_EN
        IND_PTR: begin
          if (dmem_resp) begin
            dmem_address <= ptr_word;
            err          <= ptr_misalign;
            tcnt         <= '0;
          end else if (tmo_hit) begin
            err       <= 1'b1;
            rdata_out <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
